// File: rtl/decode_pkg.sv
// Shared opcode constants, format encoding and the decoded-instruction record
// passed between the field decoder and the decode stage registers.
package decode_pkg;

   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_OP       = 7'b0110011;

   // Widest PC carried in the record; narrower PCs are zero-extended into it.
   localparam int unsigned DEC_PC_W = 64;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_t;

   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [6:0] funct7;
   } fields_t;

   typedef struct packed {
      logic illegal;
      logic writes_rd;
      logic uses_rs1;
      logic uses_rs2;
   } flags_t;

   // Every base-format immediate fits in 32 bits, so imm is held sign-extended
   // to 32 and widened to XLEN only at the stage output.
   typedef struct packed {
      logic [DEC_PC_W-1:0] pc;
      logic [31:0]         instr;
      fields_t             fields;
      logic [31:0]         imm;
      fmt_t                fmt;
      flags_t              flags;
   } decoded_t;

   function automatic fmt_t fmt_of(input logic [6:0] opcode);
      unique case (opcode)
         OP_LUI, OP_AUIPC:                                  return FMT_U;
         OP_JAL:                                            return FMT_J;
         OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM, OP_MISC_MEM:  return FMT_I;
         OP_STORE:                                          return FMT_S;
         OP_BRANCH:                                         return FMT_B;
         OP_OP:                                             return FMT_R;
         default:                                           return FMT_ILL;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = environment driving fetch and accepting results, slave = the stage.
interface decode_stage_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [31:0]     out_instr;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [2:0]      out_funct3;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [6:0]      out_funct7;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic            out_illegal;
   logic            out_writes_rd;
   logic            out_uses_rs1;
   logic            out_uses_rs2;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_opcode, out_rd,
             out_funct3, out_rs1, out_rs2, out_funct7, out_imm, out_fmt,
             out_illegal, out_writes_rd, out_uses_rs1, out_uses_rs2
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_opcode, out_rd,
             out_funct3, out_rs1, out_rs2, out_funct7, out_imm, out_fmt,
             out_illegal, out_writes_rd, out_uses_rs1, out_uses_rs2
   );
endinterface

// File: rtl/instr_fields_decode.sv
// Combinational RV32/RV64 base-format decode: fields, format, immediate and
// operand-usage flags for one instruction word.
module instr_fields_decode
   import decode_pkg::*;
(
   input  logic [31:0]         instr,
   input  logic [DEC_PC_W-1:0] pc,
   output decoded_t            dec
);

   always_comb begin
      dec = '0;
      dec.pc             = pc;
      dec.instr          = instr;
      dec.fields.opcode  = instr[6:0];
      dec.fields.rd      = instr[11:7];
      dec.fields.funct3  = instr[14:12];
      dec.fields.rs1     = instr[19:15];
      dec.fields.rs2     = instr[24:20];
      dec.fields.funct7  = instr[31:25];
      dec.fmt            = fmt_of(instr[6:0]);

      unique case (dec.fmt)
         FMT_I:   dec.imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
         FMT_U:   dec.imm = {instr[31:12], 12'b0};
         FMT_J:   dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
         default: dec.imm = '0;
      endcase

      dec.flags.illegal   = (dec.fmt == FMT_ILL);
      dec.flags.writes_rd = (dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) &&
                            (instr[11:7] != 5'd0);
      dec.flags.uses_rs1  = dec.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
      dec.flags.uses_rs2  = dec.fmt inside {FMT_R, FMT_S, FMT_B};
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes at the input, holds results in a main
// register backed by a one-entry skid so fetch sees a purely registered ready.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   decode_stage_if.slave  bus
);

   logic                main_valid;
   logic                skid_valid;
   decoded_t            main_q;
   decoded_t            skid_q;
   decoded_t            dec_in;
   logic [DEC_PC_W-1:0] pc_ext;
   logic                accept;
   logic                take;
   logic                pc_hi_unused;

   assign pc_ext = DEC_PC_W'(bus.in_pc);

   instr_fields_decode u_fields (
      .instr (bus.in_instr),
      .pc    (pc_ext),
      .dec   (dec_in)
   );

   assign accept = bus.in_valid && !skid_valid;
   assign take   = main_valid && bus.out_ready;

   // Skid is only ever filled while main is stalled, so it always holds the
   // younger entry and drains into main before main can reload from input.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (take) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end
      end else if (!main_valid || take) begin
         main_valid <= accept;
         if (accept) main_q <= dec_in;
      end else if (accept) begin
         skid_q     <= dec_in;
         skid_valid <= 1'b1;
      end
   end

   assign bus.in_ready      = !skid_valid;
   assign bus.out_valid     = main_valid;
   assign bus.out_pc        = main_q.pc[PC_W-1:0];
   assign bus.out_instr     = main_q.instr;
   assign bus.out_opcode    = main_q.fields.opcode;
   assign bus.out_rd        = main_q.fields.rd;
   assign bus.out_funct3    = main_q.fields.funct3;
   assign bus.out_rs1       = main_q.fields.rs1;
   assign bus.out_rs2       = main_q.fields.rs2;
   assign bus.out_funct7    = main_q.fields.funct7;
   assign bus.out_imm       = XLEN'(signed'(main_q.imm));
   assign bus.out_fmt       = main_q.fmt;
   assign bus.out_illegal   = main_q.flags.illegal;
   assign bus.out_writes_rd = main_q.flags.writes_rd;
   assign bus.out_uses_rs1  = main_q.flags.uses_rs1;
   assign bus.out_uses_rs2  = main_q.flags.uses_rs2;

   assign pc_hi_unused = ^main_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: XLEN=32 and XLEN=64 stages run in lockstep on one stimulus
// stream and are checked against an arithmetic reference decoder.
module tb_decode_stage;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  fmt;
      longint      imm;
      bit          illegal;
      bit          wr;
      bit          rs1u;
      bit          rs2u;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_ready = 1'b0;
   bit          started = 1'b0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q[$];

   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32), .PC_W(32)) b32 ();
   decode_stage_if #(.XLEN(64), .PC_W(32)) b64 ();

   assign b32.in_valid  = in_valid;
   assign b32.in_instr  = in_instr;
   assign b32.in_pc     = in_pc;
   assign b32.out_ready = out_ready;
   assign b64.in_valid  = in_valid;
   assign b64.in_instr  = in_instr;
   assign b64.in_pc     = in_pc;
   assign b64.out_ready = out_ready;

   decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b32)
   );
   decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b64)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
      exp_t   e;
      longint sg;
      longint sw;
      sg = w[31] ? -64'sd1 : 64'sd0;
      sw = longint'($signed(w));
      e.instr = w;
      e.pc    = pc;
      e.imm   = 0;
      case (w[6:0])
         7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = sw - longint'(w[11:0]); end
         7'h6F: begin
            e.fmt = 3'd5;
            e.imm = sg * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                    + longint'(w[30:21]) * 2;
         end
         7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: begin e.fmt = 3'd1; e.imm = sw >>> 20; end
         7'h23: begin e.fmt = 3'd2; e.imm = (sw >>> 25) * 32 + longint'(w[11:7]); end
         7'h63: begin
            e.fmt = 3'd3;
            e.imm = sg * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                    + longint'(w[11:8]) * 2;
         end
         7'h33: e.fmt = 3'd0;
         default: e.fmt = 3'd7;
      endcase
      e.illegal = (e.fmt == 3'd7);
      e.wr   = (e.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) && (w[11:7] != 5'd0);
      e.rs1u = e.fmt inside {3'd0, 3'd1, 3'd2, 3'd3};
      e.rs2u = e.fmt inside {3'd0, 3'd2, 3'd3};
      return e;
   endfunction

   // Monitor: occupancy at the falling edge, transfers just before the rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         chk("out_valid32", b32.out_valid, q.size() > 0);
         chk("in_ready32",  b32.in_ready,  q.size() < 2);
         chk("out_valid64", b64.out_valid, q.size() > 0);
         chk("in_ready64",  b64.in_ready,  q.size() < 2);
      end
      #3;
      if (rst) q.delete();
      else begin
         if (started && b32.out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_output", 1'b1, 1'b0);
            else begin
               e = q.pop_front();
               chk("instr",     b32.out_instr,     e.instr);
               chk("pc",        b32.out_pc,        e.pc);
               chk("opcode",    b32.out_opcode,    e.instr[6:0]);
               chk("rd",        b32.out_rd,        e.instr[11:7]);
               chk("funct3",    b32.out_funct3,    e.instr[14:12]);
               chk("rs1",       b32.out_rs1,       e.instr[19:15]);
               chk("rs2",       b32.out_rs2,       e.instr[24:20]);
               chk("funct7",    b32.out_funct7,    e.instr[31:25]);
               chk("imm32",     b32.out_imm,       64'(e.imm[31:0]));
               chk("fmt",       b32.out_fmt,       e.fmt);
               chk("illegal",   b32.out_illegal,   e.illegal);
               chk("writes_rd", b32.out_writes_rd, e.wr);
               chk("uses_rs1",  b32.out_uses_rs1,  e.rs1u);
               chk("uses_rs2",  b32.out_uses_rs2,  e.rs2u);
               chk("imm64",     b64.out_imm,       e.imm);
               chk("fmt64",     b64.out_fmt,       e.fmt);
               chk("instr64",   b64.out_instr,     e.instr);
            end
         end
         if (flush) q.delete();
      end
   end

   task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] pc,
                        input bit ordy, input bit fl, input bit r, output bit acc);
      @(negedge clk);
      #1;
      in_valid  = v;
      in_instr  = w;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      acc = v && b32.in_ready && !fl && !r;
      if (acc) q.push_back(model(w, pc));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 13))
         0:  w[6:0] = 7'h37;
         1:  w[6:0] = 7'h17;
         2:  w[6:0] = 7'h6F;
         3:  w[6:0] = 7'h67;
         4:  w[6:0] = 7'h03;
         5:  w[6:0] = 7'h13;
         6:  w[6:0] = 7'h73;
         7:  w[6:0] = 7'h0F;
         8:  w[6:0] = 7'h23;
         9:  w[6:0] = 7'h63;
         10: w[6:0] = 7'h33;
         11: w = 32'h0;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      bit acc;
      logic [31:0] w;
      logic [31:0] pc;

      drive(0, 0, 0, 0, 0, 1, acc);
      drive(0, 0, 0, 0, 0, 1, acc);
      drive(0, 0, 0, 0, 0, 0, acc);
      started = 1'b1;
      chk("rst_out_valid", b32.out_valid, 1'b0);
      chk("rst_in_ready",  b32.in_ready,  1'b1);
      chk("rst_out_instr", b32.out_instr, 32'h0);
      chk("rst_out_pc",    b32.out_pc,    32'h0);
      chk("rst_out_imm",   b64.out_imm,   64'h0);
      chk("rst_out_fmt",   b32.out_fmt,   3'd0);

      drive(1, 32'hFFF00093, 32'h100, 1, 0, 0, acc);
      drive(1, 32'h0020A423, 32'h104, 1, 0, 0, acc);
      drive(1, 32'hFE000EE3, 32'h108, 1, 0, 0, acc);
      drive(1, 32'h800000B7, 32'h10C, 1, 0, 0, acc);
      drive(1, 32'h00000000, 32'h110, 1, 0, 0, acc);
      drive(0, 0, 0, 1, 0, 0, acc);
      drive(0, 0, 0, 1, 0, 0, acc);

      drive(1, 32'h00100113, 32'h200, 0, 0, 0, acc);
      drive(1, 32'h00208193, 32'h204, 0, 0, 0, acc);
      drive(1, 32'h00310213, 32'h208, 0, 0, 0, acc);
      chk("stall_c_held", acc, 1'b0);
      acc = 0;
      for (int i = 0; i < 6 && !acc; i++) drive(1, 32'h00310213, 32'h208, 1, 0, 0, acc);
      chk("stall_c_accepted", acc, 1'b1);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0, acc);

      drive(1, 32'h00500293, 32'h300, 0, 0, 0, acc);
      drive(1, 32'h00600313, 32'h304, 0, 0, 0, acc);
      drive(1, 32'h00700393, 32'h308, 0, 1, 0, acc);
      drive(0, 0, 0, 1, 0, 0, acc);
      drive(0, 0, 0, 1, 0, 0, acc);

      drive(1, 32'h00800413, 32'h400, 0, 0, 0, acc);
      drive(1, 32'h00900493, 32'h404, 0, 0, 0, acc);
      drive(1, 32'h00A00513, 32'h408, 0, 0, 1, acc);
      drive(0, 0, 0, 1, 0, 0, acc);
      drive(0, 0, 0, 1, 0, 0, acc);

      pc = 32'h1000;
      for (int i = 0; i < 600; i++) begin
         w = rand_instr();
         drive($urandom_range(0, 3) != 0, w, pc, $urandom_range(0, 9) < 6,
               $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0, acc);
         if (acc) pc = pc + 4;
      end

      for (int i = 0; i < 10 && q.size() != 0; i++) drive(0, 0, 0, 1, 0, 0, acc);
      drive(0, 0, 0, 1, 0, 0, acc);
      chk("drain_empty", q.size(), 0);
      @(negedge clk);
      #5;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
